// File: rtl/ni_flit_injector_if.sv
// PE-side injection bundle: packet request, payload stream, flit/credit link to the router local port.
// The injector uses the slave modport; the PE/router side uses master.
interface ni_flit_injector_if #(
   parameter int LEN_W = 4
);
   logic             pkt_valid;
   logic             pkt_ready;
   logic [2:0]       pkt_dest_x;
   logic [2:0]       pkt_dest_y;
   logic [LEN_W-1:0] pkt_len;
   logic             pkt_vc;
   logic             pay_valid;
   logic             pay_ready;
   logic [47:0]      pay_data;
   logic [63:0]      flit_out;
   logic             flit_out_valid;
   logic [1:0]       flit_out_vc;
   logic [1:0]       credit_in;
   logic             busy;
   logic             pkt_sent;

   modport master (
      output pkt_valid, pkt_dest_x, pkt_dest_y, pkt_len, pkt_vc,
      output pay_valid, pay_data, credit_in,
      input  pkt_ready, pay_ready, flit_out, flit_out_valid, flit_out_vc, busy, pkt_sent
   );

   modport slave (
      input  pkt_valid, pkt_dest_x, pkt_dest_y, pkt_len, pkt_vc,
      input  pay_valid, pay_data, credit_in,
      output pkt_ready, pay_ready, flit_out, flit_out_valid, flit_out_vc, busy, pkt_sent
   );
endinterface

// File: rtl/ni_flit_injector.sv
// Network-interface transmitter: turns a PE packet request plus payload words into
// credit-gated wormhole HEAD/BODY/TAIL flits on one VC of the router local port.
module ni_flit_injector #(
   parameter int BUF_DEPTH = 4,
   parameter int CNT_W     = 3,
   parameter int LEN_W     = 4
) (
   input  logic              clk,
   input  logic              rst,
   ni_flit_injector_if.slave bus
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_e;

   localparam logic [2:0]       FT_HEAD      = 3'b001;
   localparam logic [2:0]       FT_BODY      = 3'b010;
   localparam logic [2:0]       FT_TAIL      = 3'b011;
   localparam logic [2:0]       FT_HEAD_TAIL = 3'b100;
   localparam logic [CNT_W-1:0] CRED_MAX     = CNT_W'(BUF_DEPTH);
   localparam logic [LEN_W-1:0] LEN_ONE      = LEN_W'(1);

   state_e                  state_q;
   logic [2:0]              dest_x_q;
   logic [2:0]              dest_y_q;
   logic                    vc_q;
   logic [LEN_W-1:0]        rem_q;
   logic                    first_q;
   logic [6:0]              pkt_id_q;
   logic [1:0][CNT_W-1:0]   credit_q;
   logic [1:0][CNT_W-1:0]   credit_d;
   logic [63:0]             flit_q;
   logic                    flit_valid_q;
   logic [1:0]              flit_vc_q;
   logic                    pkt_sent_q;

   logic                    pay_ready;
   logic                    consume;
   logic [1:0]              send_vc;
   logic [2:0]              flit_type;
   logic [LEN_W-1:0]        len_eff;

   // Credit availability comes from the registered counter only, so a credit
   // arriving this cycle cannot enable a send this cycle.
   assign pay_ready = (state_q == S_SEND) && (credit_q[vc_q] != '0);
   assign consume   = pay_ready && bus.pay_valid;
   assign send_vc   = consume ? (vc_q ? 2'b10 : 2'b01) : 2'b00;
   assign len_eff   = (bus.pkt_len == '0) ? LEN_ONE : bus.pkt_len;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      flit_type = FT_BODY;
      if (first_q && rem_q == LEN_ONE) begin
         flit_type = FT_HEAD_TAIL;
      end else if (first_q) begin
         flit_type = FT_HEAD;
      end else if (rem_q == LEN_ONE) begin
         flit_type = FT_TAIL;
      end
   end

   // Send and return in the same cycle cancel; a return into a full counter is dropped.
   always_comb begin
      credit_d = credit_q;
      for (int v = 0; v < 2; v++) begin
         if (send_vc[v] && !bus.credit_in[v]) begin
            credit_d[v] = credit_q[v] - CNT_W'(1);
         end else if (bus.credit_in[v] && !send_vc[v] && credit_q[v] != CRED_MAX) begin
            credit_d[v] = credit_q[v] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         dest_x_q     <= '0;
         dest_y_q     <= '0;
         vc_q         <= 1'b0;
         rem_q        <= '0;
         first_q      <= 1'b0;
         pkt_id_q     <= '0;
         credit_q     <= {2{CRED_MAX}};
         flit_q       <= '0;
         flit_valid_q <= 1'b0;
         flit_vc_q    <= '0;
         pkt_sent_q   <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
         credit_q     <= credit_d;
         flit_valid_q <= 1'b0;
         pkt_sent_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.pkt_valid) begin
                  dest_x_q <= bus.pkt_dest_x;
                  dest_y_q <= bus.pkt_dest_y;
                  vc_q     <= bus.pkt_vc;
                  rem_q    <= len_eff;
                  first_q  <= 1'b1;
                  state_q  <= S_SEND;
               end
            end
            S_SEND: begin
               if (consume) begin
                  flit_q       <= {dest_x_q, dest_y_q, flit_type, pkt_id_q, bus.pay_data};
                  flit_valid_q <= 1'b1;
                  flit_vc_q    <= {1'b0, vc_q};
                  first_q      <= 1'b0;
                  rem_q        <= rem_q - LEN_ONE;
                  if (rem_q == LEN_ONE) begin
                     pkt_sent_q <= 1'b1;
                     pkt_id_q   <= pkt_id_q + 7'd1;
                     state_q    <= S_IDLE;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.pkt_ready      = (state_q == S_IDLE);
   assign bus.pay_ready      = pay_ready;
   assign bus.busy           = (state_q == S_SEND);
   assign bus.flit_out       = flit_q;
   assign bus.flit_out_valid = flit_valid_q;
   assign bus.flit_out_vc    = flit_vc_q;
   assign bus.pkt_sent       = pkt_sent_q;

endmodule

// File: tb/tb_ni_flit_injector.sv
// Randomised and directed bench for ni_flit_injector: a packet-level model predicts every
// output each cycle, and a router stub returns credits as its buffer drains.
module tb_ni_flit_injector;
   localparam int BUF_DEPTH = 4;
   localparam int CNT_W     = 3;
   localparam int LEN_W     = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ni_flit_injector_if #(.LEN_W(LEN_W)) bus();

   ni_flit_injector #(
      .BUF_DEPTH(BUF_DEPTH),
      .CNT_W    (CNT_W),
      .LEN_W    (LEN_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Packet-level model: current packet, flits already sent from it, credits per VC.
   bit          m_idle;
   int          m_len;
   int          m_k;
   bit          m_vc;
   logic [2:0]  m_dx;
   logic [2:0]  m_dy;
   int          m_id;
   int          m_cred[2];
   logic [63:0] e_flit;
   bit          e_valid;
   bit          e_sent;
   logic [1:0]  e_vc;
   bit          s_consume;
   bit          s_was_idle;
   bit          s_send;

   int cyc = 0;
   int last_sent = -1;
   int sent_cnt = 0;
   int ids_q[$];
   int types_q[$];
   int gaps_q[$];

   function automatic logic [2:0] ftype(input int k, input int len);
      if (len == 1) return 3'b100;
      if (k == 0) return 3'b001;
      if (k == len - 1) return 3'b011;
      return 3'b010;
   endfunction

   always @(negedge clk) begin : compare
      cyc++;
      if (rst) begin
         m_idle = 1'b1; m_len = 0; m_k = 0; m_vc = 1'b0; m_dx = '0; m_dy = '0; m_id = 0;
         m_cred[0] = BUF_DEPTH; m_cred[1] = BUF_DEPTH;
         e_flit = '0; e_valid = 1'b0; e_sent = 1'b0; e_vc = '0;
         last_sent = -1;
         check("rst_flit_out", bus.flit_out, 64'h0);
         check("rst_flit_valid", bus.flit_out_valid, 0);
         check("rst_flit_vc", bus.flit_out_vc, 0);
         check("rst_pkt_sent", bus.pkt_sent, 0);
         check("rst_busy", bus.busy, 0);
         check("rst_pkt_ready", bus.pkt_ready, 1);
      end else begin
         check("pkt_ready", bus.pkt_ready, m_idle);
         check("busy", bus.busy, !m_idle);
         check("pay_ready", bus.pay_ready, !m_idle && m_cred[m_vc] != 0);
         check("flit_valid", bus.flit_out_valid, e_valid);
         check("flit_out", bus.flit_out, e_flit);
         check("flit_vc", bus.flit_out_vc, e_vc);
         check("pkt_sent", bus.pkt_sent, e_sent);

         if (bus.flit_out_valid) begin
            ids_q.push_back(int'(bus.flit_out[54:48]));
            types_q.push_back(int'(bus.flit_out[57:55]));
            if ((bus.flit_out[57:55] == 3'b001 || bus.flit_out[57:55] == 3'b100) && last_sent >= 0)
               gaps_q.push_back(cyc - last_sent);
         end
         if (bus.pkt_sent) begin
            last_sent = cyc;
            sent_cnt++;
         end

         s_was_idle = m_idle;
         s_consume  = !m_idle && bus.pay_valid && m_cred[m_vc] != 0;
         for (int v = 0; v < 2; v++) begin
            s_send = s_consume && (m_vc == v[0]);
            if (bus.credit_in[v])
               check("credit_overflow", (m_cred[v] == BUF_DEPTH) && !s_send, 0);
            if (s_send && !bus.credit_in[v]) m_cred[v]--;
            else if (!s_send && bus.credit_in[v] && m_cred[v] < BUF_DEPTH) m_cred[v]++;
         end
         e_valid = 1'b0;
         e_sent  = 1'b0;
         if (s_consume) begin
            e_flit  = {m_dx, m_dy, ftype(m_k, m_len), 7'(m_id), bus.pay_data};
            e_valid = 1'b1;
            e_vc    = {1'b0, m_vc};
            m_k++;
            if (m_k == m_len) begin
               e_sent = 1'b1;
               m_id   = (m_id + 1) % 128;
               m_idle = 1'b1;
            end
         end else if (s_was_idle && bus.pkt_valid) begin
            m_dx   = bus.pkt_dest_x;
            m_dy   = bus.pkt_dest_y;
            m_vc   = bus.pkt_vc;
            m_len  = (bus.pkt_len == '0) ? 1 : int'(bus.pkt_len);
            m_k    = 0;
            m_idle = 1'b0;
         end
      end
   end

   // Router stub: counts flits held per VC and frees them as credit pulses.
   int         occ[2];
   logic [1:0] man_req = 2'b00;
   int         auto_pct = 0;

   initial begin : credit_drv
      bus.credit_in = 2'b00;
      occ[0] = 0; occ[1] = 0;
      forever begin
         @(posedge clk); #2;
         if (rst) begin
            occ[0] = 0; occ[1] = 0;
            bus.credit_in = 2'b00;
            man_req = 2'b00;
         end else begin
            if (bus.flit_out_valid) occ[bus.flit_out_vc[0]]++;
            for (int v = 0; v < 2; v++) begin
               bus.credit_in[v] = 1'b0;
               if (occ[v] > 0 && (man_req[v] || int'($urandom_range(99)) < auto_pct)) begin
                  bus.credit_in[v] = 1'b1;
                  occ[v]--;
               end
            end
            man_req = 2'b00;
         end
      end
   end

   task automatic junk_request();
      bus.pkt_dest_x = 3'($urandom);
      bus.pkt_dest_y = 3'($urandom);
      bus.pkt_len    = LEN_W'($urandom);
      bus.pkt_vc     = 1'($urandom);
   endtask

   task automatic start_pkt(input logic [2:0] x, input logic [2:0] y,
                            input logic [LEN_W-1:0] len, input logic vc);
      int n = 0;
      while (!bus.pkt_ready && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.pkt_ready) check("start_timeout", 0, 1);
      bus.pkt_valid  = 1'b1;
      bus.pkt_dest_x = x;
      bus.pkt_dest_y = y;
      bus.pkt_len    = len;
      bus.pkt_vc     = vc;
      @(posedge clk); #1;
      bus.pkt_valid = 1'b0;
      junk_request();
   endtask

   task automatic feed(input int n, input int valid_pct, output int cycles);
      int got = 0;
      cycles = 0;
      while (got < n && cycles < 500) begin
         bus.pay_valid = int'($urandom_range(99)) < valid_pct;
         bus.pay_data  = 48'({$urandom(), $urandom()});
         if (bus.pay_valid && bus.pay_ready) got++;
         @(posedge clk); #1;
         cycles++;
      end
      bus.pay_valid = 1'b0;
      if (got < n) check("feed_timeout", got, n);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin : main
      int c;
      int acc;
      int budget;
      int sent0;
      int exp_t2[6] = '{1, 2, 2, 2, 2, 3};
      int exp_t6[4] = '{1, 2, 2, 3};
      bit pat[6]    = '{1, 0, 1, 1, 0, 1};

      bus.pkt_valid = 1'b0;
      bus.pay_valid = 1'b0;
      bus.pay_data  = '0;
      junk_request();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Single-flit packet, literal flit value
      auto_pct = 0;
      start_pkt(3'd2, 3'd3, 4'd1, 1'b0);
      bus.pay_data  = 48'hABC;
      bus.pay_valid = 1'b1;
      @(posedge clk); #1;
      bus.pay_valid = 1'b0;
      check("t1_flit", bus.flit_out, 64'h4E00_0000_0000_0ABC);
      check("t1_valid", bus.flit_out_valid, 1);
      check("t1_sent", bus.pkt_sent, 1);
      check("t1_vc", bus.flit_out_vc, 2'b00);

      // len 6 on vc1: four flits on the initial credits, stall, then two returned credits
      repeat (2) @(posedge clk); #1;
      types_q.delete();
      start_pkt(3'd5, 3'd1, 4'd6, 1'b1);
      feed(4, 100, c);
      check("t2_consecutive", c, 4);
      bus.pay_valid = 1'b1;
      check("t2_stall", bus.pay_ready, 0);
      @(posedge clk); #1;
      check("t2_stall_hold", bus.pay_ready, 0);
      bus.pay_valid = 1'b0;
      man_req = 2'b10;
      @(posedge clk); #1;
      man_req = 2'b10;
      @(posedge clk); #1;
      feed(2, 100, c);
      repeat (3) @(posedge clk); #1;
      check("t2_nflits", types_q.size(), 6);
      for (int i = 0; i < 6 && i < types_q.size(); i++) check("t2_type", types_q[i], exp_t2[i]);
      check("t2_cred1_end", m_cred[1], 0);

      // Send and credit on the same VC in one cycle; other VC fills back to BUF_DEPTH
      repeat (3) begin
         man_req = 2'b10;
         @(posedge clk); #1;
      end
      start_pkt(3'd0, 3'd7, 4'd3, 1'b0);
      bus.pay_valid = 1'b1;
      bus.pay_data  = 48'h111;
      @(posedge clk); #1;
      bus.pay_data = 48'h222;
      man_req = 2'b11;
      @(posedge clk); #1;
      check("t3_cred0", m_cred[0], 2);
      check("t3_cred1", m_cred[1], 4);
      bus.pay_data = 48'h333;
      @(posedge clk); #1;
      bus.pay_valid = 1'b0;
      check("t3_cred0_after", m_cred[0], 1);

      auto_pct = 100;
      repeat (12) @(posedge clk); #1;
      check("settle_cred0", m_cred[0], 4);

      // Gapped payload stream on a len-4 packet
      types_q.delete();
      start_pkt(3'd4, 3'd2, 4'd4, 1'b1);
      for (int i = 0; i < 6; i++) begin
         bus.pay_valid = pat[i];
         bus.pay_data  = 48'({$urandom(), $urandom()});
         @(posedge clk); #1;
      end
      bus.pay_valid = 1'b0;
      repeat (3) @(posedge clk); #1;
      check("t6_nflits", types_q.size(), 4);
      for (int i = 0; i < 4 && i < types_q.size(); i++) check("t6_type", types_q[i], exp_t6[i]);

      // Random traffic: random lengths/VCs, request noise during SEND, random credit return
      auto_pct = 40;
      acc = 0;
      budget = 0;
      sent0 = sent_cnt;
      while ((acc < 40 || bus.busy) && budget < 8000) begin
         bus.pkt_valid = (acc < 40) && ($urandom_range(1) == 1);
         junk_request();
         if (bus.pkt_valid && bus.pkt_ready) acc++;
         bus.pay_valid = int'($urandom_range(99)) < 70;
         bus.pay_data  = 48'({$urandom(), $urandom()});
         @(posedge clk); #1;
         budget++;
      end
      bus.pkt_valid = 1'b0;
      bus.pay_valid = 1'b0;
      repeat (2) @(posedge clk); #1;
      check("rand_pkts", sent_cnt - sent0, 40);

      // Reset mid-packet after HEAD and BODY
      auto_pct = 100;
      repeat (8) @(posedge clk); #1;
      start_pkt(3'd1, 3'd1, 4'd5, 1'b0);
      feed(2, 100, c);
      check("t5_pre_valid", bus.flit_out_valid, 1);
      #2 rst = 1'b1;
      #1;
      check("t5_async_valid", bus.flit_out_valid, 0);
      check("t5_async_flit", bus.flit_out, 64'h0);
      check("t5_async_vc", bus.flit_out_vc, 0);
      check("t5_async_busy", bus.busy, 0);
      check("t5_async_sent", bus.pkt_sent, 0);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      check("t5_cred0", m_cred[0], 4);
      check("t5_cred1", m_cred[1], 4);
      ids_q.delete();
      gaps_q.delete();
      types_q.delete();

      // 129 back-to-back single-flit packets: id wrap and minimum idle gap
      acc = 0;
      budget = 0;
      sent0 = sent_cnt;
      while (sent_cnt - sent0 < 129 && budget < 3000) begin
         if (bus.pkt_ready && acc < 129) begin
            bus.pkt_valid  = 1'b1;
            bus.pkt_len    = LEN_W'($urandom_range(1));
            bus.pkt_vc     = 1'($urandom);
            bus.pkt_dest_x = 3'($urandom);
            bus.pkt_dest_y = 3'($urandom);
            acc++;
         end else begin
            bus.pkt_valid = 1'b0;
         end
         bus.pay_valid = 1'b1;
         bus.pay_data  = 48'({$urandom(), $urandom()});
         @(posedge clk); #1;
         budget++;
      end
      bus.pkt_valid = 1'b0;
      bus.pay_valid = 1'b0;
      repeat (3) @(posedge clk); #1;
      check("t4_first_type", (types_q.size() > 0) ? types_q[0] : -1, 4);
      check("t4_nids", ids_q.size(), 129);
      for (int i = 0; i < ids_q.size(); i++) check("t4_id", ids_q[i], i % 128);
      check("t4_ngaps", gaps_q.size(), 128);
      for (int i = 0; i < gaps_q.size(); i++) check("t4_gap", gaps_q[i], 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
